// File: rtl/sym_shifter_pipe.sv
// Two-stage pipelined symbol shifter for packed symbol vectors.
// Stage 1 captures the request and its legality; stage 2 registers the
// shifted word, which drives out_data/out_shift_ok directly. Shift, fill-left
// and rotate-right are built from a log2 mux tree, one layer per shift bit.
module sym_shifter_pipe #(
  parameter int SYM_W     = 5,
  parameter int NUM_SYM   = 10,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W*NUM_SYM-1:0] in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic [1:0]               in_mode,
  input  logic [SYM_W-1:0]         in_fill,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SYM_W*NUM_SYM-1:0] out_data,
  output logic                     out_shift_ok,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int DATA_W = SYM_W * NUM_SYM;
  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

  typedef enum logic [1:0] {
    MODE_SHR = 2'b00,
    MODE_SHL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Stage-1 payload
  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [SHIFT_W-1:0] s1_shift;
  mode_e              s1_mode;
  logic [SYM_W-1:0]   s1_fill;
  logic               s1_legal;

  logic              s2_valid;
  logic              s2_load;
  logic              in_fire;
  logic              in_legal;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] nxt;
  logic [DATA_W-1:0] shifted;

  assign in_legal  = (in_shift <= MAX_S) && (in_mode != MODE_RSV);
  assign s2_load   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_load;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Log2 mux tree: layer b conditionally moves every symbol by 2**b places.
  // All source indices are reduced mod NUM_SYM so selects stay in range; the
  // fill decision is made separately from the unwrapped position.
  always_comb begin
    // NOTE: cur/nxt are assigned before any conditional use so no latch is inferred.
    cur = s1_data;
    nxt = s1_data;
    for (int b = 0; b < SHIFT_W; b++) begin
      nxt = cur;
      if (s1_shift[b]) begin
        for (int i = 0; i < NUM_SYM; i++) begin
          case (s1_mode)
            MODE_SHL:
              nxt[i*SYM_W +: SYM_W] = (i >= (1 << b))
                ? cur[((i + NUM_SYM - ((1 << b) % NUM_SYM)) % NUM_SYM)*SYM_W +: SYM_W]
                : s1_fill;
            MODE_ROR:
              nxt[i*SYM_W +: SYM_W] = cur[((i + (1 << b)) % NUM_SYM)*SYM_W +: SYM_W];
            default:
              nxt[i*SYM_W +: SYM_W] = (i + (1 << b) < NUM_SYM)
                ? cur[((i + (1 << b)) % NUM_SYM)*SYM_W +: SYM_W]
                : s1_fill;
          endcase
        end
      end
      cur = nxt;
    end
    shifted = s1_legal ? cur : {NUM_SYM{s1_fill}};
  end

  // Stage-1 payload capture whenever a new request is accepted.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the valid flags alone qualify them.
    if (in_fire) begin
      s1_data  <= in_data;
      s1_shift <= in_shift;
      s1_mode  <= mode_e'(in_mode);
      s1_fill  <= in_fill;
      s1_legal <= in_legal;
    end
  end

  // Valid flags, output register and saturating reject counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      out_data     <= '0;
      out_shift_ok <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data     <= shifted;
          out_shift_ok <= s1_legal;
        end
      end
      if (in_fire && !in_legal && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/sym_shifter_pipe.md
Name: sym_shifter_pipe

Overview:
- Parametrised, pipelined symbol shifter for packed symbol vectors. Generalises the combinational 50-bit/5-bit-symbol right shifter.
- Adds configurable symbol width and count, shift/rotate modes, valid/ready flow control and a registered output.
- Sits between the lane-alignment logic and the downstream packer. Also counts rejected (out-of-range) shift requests.

Parameters:
SYM_W, 5, bits per symbol
NUM_SYM, 10, symbols per word; data width is SYM_W*NUM_SYM
SHIFT_W, 3, width of the shift-amount field, in symbols
MAX_SHIFT, 4, largest legal shift amount; must be < NUM_SYM
CNT_W, 16, width of the rejected-request counter

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept the input this cycle
in_data  in  SYM_W*NUM_SYM  input word; symbol k occupies bits [k*SYM_W +: SYM_W]
in_shift  in  SHIFT_W  shift amount, in symbols
in_mode  in  2  00 shift right with fill, 01 shift left with fill, 10 rotate right, 11 reserved
in_fill  in  SYM_W  fill symbol
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts the output
out_data  out  SYM_W*NUM_SYM  shifted word
out_shift_ok  out  1  1 when the request was legal
err_cnt  out  CNT_W  saturating count of illegal requests accepted

Behaviour:
- Reset: clk and rst_n only, no asynchronous path. While rst_n=0 at an edge: out_valid=0, out_data=0, out_shift_ok=0, err_cnt=0, all stage-valid flags cleared, and in-flight transactions are dropped. in_ready=1 from the first cycle after reset releases.
- Pipeline: two stages.
  - S1 registers in_data, in_shift, in_mode, in_fill and the legality flag.
  - S2 registers the shift result, which drives out_data and out_shift_ok directly.
  - Latency is 2 cycles from the accepting edge to out_valid=1.
- Throughput: one transaction per cycle when out_ready=1.
- Handshake:
  - Input transfers on an edge where in_valid&in_ready; output transfers on an edge where out_valid&out_ready.
  - S2 loads when S2 is empty or out_ready=1. S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = ~s1_valid | s2_load. It is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - out_valid, once asserted, stays high with out_data and out_shift_ok stable until the output transfers.
- Legality: legal = (in_shift <= MAX_SHIFT) && (in_mode != 11).
- Data function, legal request, amount s, output symbol i (0..NUM_SYM-1):
  - mode 00: in symbol i+s if i+s < NUM_SYM, else in_fill.
  - mode 01: in symbol i-s if i >= s, else in_fill.
  - mode 10: in symbol (i+s) mod NUM_SYM; in_fill is ignored.
  - s=0: output equals input in every mode.
- Illegal request:
  - Still accepted and passed through the pipeline in order.
  - out_data = in_fill replicated NUM_SYM times; out_shift_ok=0.
- err_cnt:
  - Increments by 1 on each input transfer whose legality flag is 0, at the accepting edge.
  - Saturates at all-ones; it does not wrap.
- Ordering: strict FIFO, no reordering or dropping, except on reset.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 transfers out and in on the same edge. Occupancy stays at 2 and there is no bubble.
- Shift selection is implemented as a log2 mux tree (one stage per shift bit), not a per-symbol case table.

Test Plan:
- Defaults; in_data symbol k = k; mode 00, shift 2, fill 31, out_ready=1 -> 2 cycles later out_valid=1, symbols = 2,3,4,5,6,7,8,9,31,31; out_shift_ok=1.
- Mode 01, shift 3, fill 31 -> symbols = 31,31,31,0,1,2,3,4,5,6. Mode 10, shift 4 -> symbols = 4,5,6,7,8,9,0,1,2,3.
- Shift 5 (mode 00), then mode 11 with shift 1, fill 7 -> both outputs are ten symbols of 7 with out_shift_ok=0; err_cnt steps 0->1->2.
- Back-to-back: 3 transfers with out_ready=0 -> in_ready falls after 2 are accepted. Raise out_ready -> outputs emerge in order, one per cycle, with data held stable while stalled.
- Pre-load err_cnt near saturation (CNT_W=2 build) and send 5 illegal requests -> err_cnt = 3 and holds.
- Assert rst_n=0 for one edge with 2 transactions in flight -> next cycle out_valid=0, err_cnt=0, in_ready=1, and nothing from before reset is emitted.
